// File: rtl/sys_mem_addr_gen.sv
// rtl/sys_mem_addr_gen.sv - per-agent circular-buffer address generator
// Turns agent bursts into one or two wrap-split memory commands inside each agent's partition.
module sys_mem_addr_gen #(
  parameter int MEM_ADDR_W = 27,
  parameter int NUM_AGENTS = 2,
  parameter int BURST_W    = 8,
  parameter int AGENT_ID_W = $clog2(NUM_AGENTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [AGENT_ID_W-1:0] req_agent_id,
  input  logic                  req_wr,
  input  logic [BURST_W-1:0]    req_len,
  output logic [AGENT_ID_W-1:0] part_agent_id,
  input  logic [MEM_ADDR_W-1:0] part_start_addr,
  input  logic [MEM_ADDR_W-1:0] part_end_addr,
  input  logic [NUM_AGENTS-1:0] ptr_clr,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_wr,
  output logic [MEM_ADDR_W-1:0] mem_cmd_addr,
  output logic [BURST_W-1:0]    mem_cmd_len,
  output logic [AGENT_ID_W-1:0] mem_cmd_agent_id,
  output logic                  err_valid,
  output logic [1:0]            err_code
);

  localparam int SW = MEM_ADDR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_CALC, S_ISSUE1, S_ISSUE2} state_t;
  state_t state, state_nx;

  logic                  ready_en;
  logic [AGENT_ID_W-1:0] id_q;
  logic                  wr_q;
  logic [BURST_W-1:0]    len_q;
  logic [BURST_W-1:0]    len2_q;
  logic [BURST_W-1:0]    cmd_len_q;
  logic [MEM_ADDR_W-1:0] start_q;
  logic [MEM_ADDR_W-1:0] off_q;
  logic [MEM_ADDR_W-1:0] cmd_addr_q;
  logic [SW-1:0]         size_q;
  logic                  clr_seen;

  logic [MEM_ADDR_W-1:0] wr_off [NUM_AGENTS];
  logic [MEM_ADDR_W-1:0] rd_off [NUM_AGENTS];
  logic [SW-1:0]         fill   [NUM_AGENTS];

  logic [SW-1:0]         size_c, len_x, room_c, commit_sum;
  logic [MEM_ADDR_W-1:0] off_c, wrap_c;
  logic [BURST_W-1:0]    len1_c;
  logic                  bad_part, ovf, unf, accept, hs, final_hs;

  assign accept   = req_valid && req_ready;
  assign hs       = mem_cmd_valid && mem_cmd_ready;
  assign final_hs = hs && ((state == S_ISSUE2) || (state == S_ISSUE1 && len2_q == '0));

  assign size_c   = {1'b0, part_end_addr} - {1'b0, part_start_addr} + SW'(1);
  assign len_x    = SW'(len_q);
  assign off_c    = wr_q ? wr_off[id_q] : rd_off[id_q];
  assign room_c   = size_c - {1'b0, off_c};
  assign bad_part = part_end_addr < part_start_addr;
  assign ovf      = wr_q && (len_x > (size_c - fill[id_q]));
  assign unf      = !wr_q && (len_x > fill[id_q]);
  assign len1_c   = (len_x > room_c) ? room_c[BURST_W-1:0] : len_q;

  // off+len is below 2*size, so a single conditional subtract gives the modulo
  assign commit_sum = {1'b0, off_q} + len_x;
  assign wrap_c     = MEM_ADDR_W'((commit_sum >= size_q) ? (commit_sum - size_q) : commit_sum);

  assign req_ready        = ready_en && (state == S_IDLE);
  assign mem_cmd_valid    = (state == S_ISSUE1) || (state == S_ISSUE2);
  assign mem_cmd_wr       = wr_q;
  assign mem_cmd_addr     = cmd_addr_q;
  assign mem_cmd_len      = cmd_len_q;
  assign mem_cmd_agent_id = id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = S_LOOKUP;
      S_LOOKUP: state_nx = S_CALC;
      S_CALC:   state_nx = (bad_part || ovf || unf || len_q == '0) ? S_IDLE : S_ISSUE1;
      S_ISSUE1: if (hs) state_nx = (len2_q != '0) ? S_ISSUE2 : S_IDLE;
      S_ISSUE2: if (hs) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en      <= 1'b0;
      id_q          <= '0;
      wr_q          <= 1'b0;
      len_q         <= '0;
      len2_q        <= '0;
      cmd_len_q     <= '0;
      start_q       <= '0;
      off_q         <= '0;
      cmd_addr_q    <= '0;
      size_q        <= '0;
      clr_seen      <= 1'b0;
      part_agent_id <= '0;
      err_valid     <= 1'b0;
      err_code      <= 2'd0;
    end else begin
      ready_en  <= 1'b1;
      err_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            id_q          <= req_agent_id;
            wr_q          <= req_wr;
            len_q         <= req_len;
            part_agent_id <= req_agent_id;
          end
        end
        S_CALC: begin
          start_q    <= part_start_addr;
          size_q     <= size_c;
          off_q      <= off_c;
          clr_seen   <= ptr_clr[id_q];
          cmd_addr_q <= part_start_addr + off_c;
          cmd_len_q  <= len1_c;
          len2_q     <= len_q - len1_c;
          if (bad_part) begin
            err_valid <= 1'b1;
            err_code  <= 2'd1;
          end else if (ovf) begin
            err_valid <= 1'b1;
            err_code  <= 2'd2;
          end else if (unf) begin
            err_valid <= 1'b1;
            err_code  <= 2'd3;
          end
        end
        S_ISSUE1: begin
          clr_seen <= clr_seen | ptr_clr[id_q];
          if (hs && len2_q != '0) begin
            cmd_addr_q <= start_q;
            cmd_len_q  <= len2_q;
          end
        end
        S_ISSUE2: clr_seen <= clr_seen | ptr_clr[id_q];
        default: ;
      endcase
    end
  end

  // A clear seen while the burst is in flight cancels its commit, so the agent restarts at offset 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_AGENTS; i++) begin
        wr_off[i] <= '0;
        rd_off[i] <= '0;
        fill[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_AGENTS; i++) begin
        if (ptr_clr[i]) begin
          wr_off[i] <= '0;
          rd_off[i] <= '0;
          fill[i]   <= '0;
        end else if (final_hs && !clr_seen && id_q == AGENT_ID_W'(i)) begin
          if (wr_q) begin
            wr_off[i] <= wrap_c;
            fill[i]   <= fill[i] + len_x;
          end else begin
            rd_off[i] <= wrap_c;
            fill[i]   <= fill[i] - len_x;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sys_mem_addr_gen.sv
// tb/tb_sys_mem_addr_gen.sv - directed self-checking bench for sys_mem_addr_gen
module tb_sys_mem_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_agent_id, req_wr;
  logic [7:0]  req_len;
  logic        part_agent_id;
  logic [26:0] part_start_addr, part_end_addr;
  logic [1:0]  ptr_clr;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_wr, mem_cmd_agent_id;
  logic [26:0] mem_cmd_addr;
  logic [7:0]  mem_cmd_len;
  logic        err_valid;
  logic [1:0]  err_code;

  logic [26:0] p_start [2];
  logic [26:0] p_end   [2];

  int checks = 0;
  int failures = 0;
  int kind, cyc;
  logic        r_wr, r_aid;
  logic [26:0] r_addr;
  logic [7:0]  r_len;
  logic [1:0]  r_code;

  always #5 clk = ~clk;

  assign part_start_addr = p_start[part_agent_id];
  assign part_end_addr   = p_end[part_agent_id];

  sys_mem_addr_gen dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_agent_id(req_agent_id),
    .req_wr(req_wr), .req_len(req_len),
    .part_agent_id(part_agent_id), .part_start_addr(part_start_addr), .part_end_addr(part_end_addr),
    .ptr_clr(ptr_clr),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_wr(mem_cmd_wr),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len), .mem_cmd_agent_id(mem_cmd_agent_id),
    .err_valid(err_valid), .err_code(err_code)
  );

  // Returns at the falling edge of the cycle after the accepting edge (LOOKUP)
  task automatic send_req(input logic id, input logic wr, input logic [7:0] len);
    bit ok;
    @(negedge clk);
    req_valid = 1'b1; req_agent_id = id; req_wr = wr; req_len = len; ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL accept_timeout id=%0d wr=%0d len=%0d", id, wr, len); end
  endtask

  // kind: 0 nothing seen, 1 command handshake, 2 error pulse; cyc = falling edges waited
  task automatic wait_resp(input int bound);
    kind = 0; cyc = -1; r_wr = 0; r_aid = 0; r_addr = '0; r_len = '0; r_code = '0;
    for (int i = 0; i < bound; i++) begin
      if (mem_cmd_valid && mem_cmd_ready) begin
        kind = 1; r_wr = mem_cmd_wr; r_addr = mem_cmd_addr; r_len = mem_cmd_len; r_aid = mem_cmd_agent_id;
      end else if (err_valid) begin
        kind = 2; r_code = err_code;
      end
      if (kind != 0) begin cyc = i; @(negedge clk); break; end
      @(negedge clk);
    end
  endtask

  task automatic chk_cmd(input string name, input int ecyc, input logic ewr, input logic [26:0] eaddr,
                         input logic [7:0] elen, input logic eaid);
    checks++;
    if (kind !== 1 || cyc !== ecyc || r_wr !== ewr || r_addr !== eaddr || r_len !== elen || r_aid !== eaid) begin
      failures++;
      $display("FAIL %s got kind=%0d cyc=%0d wr=%0d addr=%h len=%0d aid=%0d want kind=1 cyc=%0d wr=%0d addr=%h len=%0d aid=%0d",
               name, kind, cyc, r_wr, r_addr, r_len, r_aid, ecyc, ewr, eaddr, elen, eaid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (req_ready !== 0 || mem_cmd_valid !== 0 || err_valid !== 0 || part_agent_id !== 0 ||
        mem_cmd_addr !== 0 || mem_cmd_len !== 0) begin
      failures++;
      $display("FAIL reset_held ready=%0d valid=%0d err=%0d pid=%0d addr=%h len=%0d want all 0",
               req_ready, mem_cmd_valid, err_valid, part_agent_id, mem_cmd_addr, mem_cmd_len);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1 || mem_cmd_valid !== 0 || err_valid !== 0 || err_code !== 0) begin
      failures++;
      $display("FAIL reset_release ready=%0d valid=%0d err=%0d code=%0d want 1 0 0 0",
               req_ready, mem_cmd_valid, err_valid, err_code);
    end
  endtask

  task automatic test_basic();
    send_req(0, 1, 16); wait_resp(20); chk_cmd("basic_wr", 2, 1, 27'h100, 16, 0);
    send_req(0, 0, 16); wait_resp(20); chk_cmd("basic_rd", 2, 0, 27'h100, 16, 0);
  endtask

  task automatic test_wrap();
    send_req(0, 1, 232); wait_resp(20); chk_cmd("fill_wr", 2, 1, 27'h110, 232, 0);
    send_req(0, 0, 232); wait_resp(20); chk_cmd("fill_rd", 2, 0, 27'h110, 232, 0);
    send_req(0, 1, 16);  wait_resp(20); chk_cmd("wrap_wr1", 2, 1, 27'h1F8, 8, 0);
    wait_resp(20); chk_cmd("wrap_wr2", 0, 1, 27'h100, 8, 0);
    send_req(0, 0, 16);  wait_resp(20); chk_cmd("wrap_rd1", 2, 0, 27'h1F8, 8, 0);
    wait_resp(20); chk_cmd("wrap_rd2", 0, 0, 27'h100, 8, 0);
  endtask

  task automatic test_over_under();
    send_req(0, 0, 4); wait_resp(20);
    checks++;
    if (kind !== 2 || r_code !== 3 || cyc !== 2) begin
      failures++; $display("FAIL underflow kind=%0d code=%0d cyc=%0d want 2 3 2", kind, r_code, cyc);
    end
    send_req(0, 1, 250); wait_resp(20); chk_cmd("wr250_1", 2, 1, 27'h108, 248, 0);
    wait_resp(20); chk_cmd("wr250_2", 0, 1, 27'h100, 2, 0);
    send_req(0, 1, 16); wait_resp(20);
    checks++;
    if (kind !== 2 || r_code !== 2 || cyc !== 2) begin
      failures++; $display("FAIL overflow kind=%0d code=%0d cyc=%0d want 2 2 2", kind, r_code, cyc);
    end
    send_req(0, 1, 6); wait_resp(20); chk_cmd("fill_to_full", 2, 1, 27'h102, 6, 0);
    send_req(0, 1, 1); wait_resp(20);
    checks++;
    if (kind !== 2 || r_code !== 2) begin
      failures++; $display("FAIL overflow_full kind=%0d code=%0d want 2 2", kind, r_code);
    end
    send_req(0, 0, 0); wait_resp(6);
    checks++;
    if (kind !== 0 || req_ready !== 1) begin
      failures++; $display("FAIL zero_len kind=%0d ready=%0d want 0 1", kind, req_ready);
    end
  endtask

  task automatic test_bad_partition();
    p_start[1] = 27'h200; p_end[1] = 27'h1FF;
    send_req(1, 1, 4);
    checks++;
    if (part_agent_id !== 1) begin failures++; $display("FAIL part_agent_id got=%0d want 1", part_agent_id); end
    wait_resp(20);
    checks++;
    if (kind !== 2 || r_code !== 1 || cyc !== 2) begin
      failures++; $display("FAIL bad_partition kind=%0d code=%0d cyc=%0d want 2 1 2", kind, r_code, cyc);
    end
    p_start[1] = 27'h400; p_end[1] = 27'h43F;
  endtask

  task automatic test_backpressure();
    bit found, stable;
    logic [26:0] a0;
    logic [7:0]  l0;
    mem_cmd_ready = 1'b0;
    send_req(1, 1, 8);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_cmd_valid) begin found = 1; break; end
      @(negedge clk);
    end
    a0 = mem_cmd_addr; l0 = mem_cmd_len;
    checks++;
    if (!found || a0 !== 27'h400 || l0 !== 8) begin
      failures++; $display("FAIL bp_cmd found=%0d addr=%h len=%0d want 1 400 8", found, a0, l0);
    end
    req_valid = 1'b1; req_agent_id = 1'b0; req_wr = 1'b0; req_len = 8'd4;
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!mem_cmd_valid || mem_cmd_addr !== a0 || mem_cmd_len !== l0 || mem_cmd_wr !== 1 || req_ready !== 0)
        stable = 0;
    end
    checks++;
    if (!stable) begin
      failures++; $display("FAIL bp_stable valid=%0d addr=%h len=%0d ready=%0d want 1 %h %0d 0",
                           mem_cmd_valid, mem_cmd_addr, mem_cmd_len, req_ready, a0, l0);
    end
    mem_cmd_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_cmd_valid !== 0 || req_ready !== 1) begin
      failures++; $display("FAIL bp_release valid=%0d ready=%0d want 0 1", mem_cmd_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(20); chk_cmd("bp_next_req", 2, 0, 27'h108, 4, 0);
  endtask

  task automatic test_ptr_clr();
    mem_cmd_ready = 1'b0;
    send_req(1, 1, 4);
    repeat (3) @(negedge clk);
    ptr_clr = 2'b10;
    @(negedge clk);
    ptr_clr = 2'b00;
    mem_cmd_ready = 1'b1;
    wait_resp(20); chk_cmd("clr_inflight", 0, 1, 27'h408, 4, 1);
    send_req(1, 1, 4); wait_resp(20); chk_cmd("clr_restart", 2, 1, 27'h400, 4, 1);
    send_req(0, 0, 4); wait_resp(20); chk_cmd("clr_other_agent", 2, 0, 27'h10C, 4, 0);
    send_req(1, 0, 4); wait_resp(20); chk_cmd("clr_read_back", 2, 0, 27'h400, 4, 1);
  endtask

  task automatic test_reset_abort();
    mem_cmd_ready = 1'b0;
    send_req(0, 1, 4);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_cmd_valid !== 0 || req_ready !== 0) begin
      failures++; $display("FAIL reset_abort valid=%0d ready=%0d want 0 0", mem_cmd_valid, req_ready);
    end
    mem_cmd_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_req(0, 1, 4); wait_resp(20); chk_cmd("post_reset_wr", 2, 1, 27'h100, 4, 0);
    send_req(0, 0, 4); wait_resp(20); chk_cmd("post_reset_rd", 2, 0, 27'h100, 4, 0);
  endtask

  initial begin
    p_start[0] = 27'h100; p_end[0] = 27'h1FF;
    p_start[1] = 27'h400; p_end[1] = 27'h43F;
    req_valid = 0; req_agent_id = 0; req_wr = 0; req_len = 0;
    ptr_clr = 2'b00; mem_cmd_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_over_under();
    test_bad_partition();
    test_backpressure();
    test_ptr_clr();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
